// File: rtl/rvx_alu_pkg.sv
// Shared ALUControl encodings, ALUOp constants and FSM state type for the RVX10 ALU execute unit.
package rvx_alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_SLT  = 5'b00101,
    ALU_ANDN = 5'b01000,
    ALU_ORN  = 5'b01001,
    ALU_XNOR = 5'b01010,
    ALU_MIN  = 5'b01011,
    ALU_MAX  = 5'b01100,
    ALU_MINU = 5'b01101,
    ALU_MAXU = 5'b01110,
    ALU_ROL  = 5'b01111,
    ALU_ROR  = 5'b10000,
    ALU_ABS  = 5'b10001
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RVX   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/rvx_alu_opdec.sv
// ALUOp/funct3/funct7/opb5 to ALUControl decode; RVX10 ops decoded only with RVX_ALU_EXT_EN.
module rvx_alu_opdec
  import rvx_alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       opb5,
  output alu_op_e    op,
  output logic       illegal
);

`ifndef RVX_ALU_EXT_EN
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
`endif

  // ALUControl table lookup; anything not listed flags illegal
  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct3)
          3'b000: begin
            if (funct7[5] && opb5) begin
              op = ALU_SUB;
            end else begin
              op = ALU_ADD;
            end
          end
          3'b010: op = ALU_SLT;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_RVX: begin
`ifdef RVX_ALU_EXT_EN
        case ({funct7, funct3})
          10'b0000000_000: op = ALU_ANDN;
          10'b0000000_001: op = ALU_ORN;
          10'b0000000_010: op = ALU_XNOR;
          10'b0000001_000: op = ALU_MIN;
          10'b0000001_001: op = ALU_MAX;
          10'b0000001_010: op = ALU_MINU;
          10'b0000001_011: op = ALU_MAXU;
          10'b0000010_000: op = ALU_ROL;
          10'b0000010_001: op = ALU_ROR;
          10'b0000011_000: op = ALU_ABS;
          default: illegal = 1'b1;
        endcase
`else
        illegal = 1'b1;
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rvx_alu_exec.sv
// Registered RVX10 ALU execute stage with valid/ready handshakes and an iterative rotate path.
// RVX_ALU_EXT_EN enables the RVX10 ops; without it ALUOp=11 is illegal and the rotate path is absent.
module rvx_alu_exec
  import rvx_alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ROT_STEP = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            opb5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  alu_op_e    dec_op;
  logic       dec_illegal;
  alu_state_e state, state_next;
  logic            out_valid_next, zero_next, illegal_next;
  logic [XLEN-1:0] result_next, alu_res;
  logic            accept, start_rot;

  rvx_alu_opdec u_opdec (
    .alu_op  (ALUOp),
    .funct3  (funct3),
    .funct7  (funct7),
    .opb5    (opb5),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

`ifdef RVX_ALU_EXT_EN
  localparam logic [SHW:0] ROT_STEP_W = (SHW+1)'(ROT_STEP);

  logic [XLEN-1:0] acc, acc_next, acc_rot;
  logic [SHW-1:0]  rem, rem_next, rot_step, shamt, first_step;
  logic            rot_left, rot_left_next, rot_more, rot_multi;

  function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] x, input logic [SHW-1:0] s);
    logic [2*XLEN-1:0] w;
    w = {x, x} << s;
    return w[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] x, input logic [SHW-1:0] s);
    logic [2*XLEN-1:0] w;
    w = {x, x} >> s;
    return w[XLEN-1:0];
  endfunction

  // Each cycle moves at most ROT_STEP positions; the accept edge takes the first slice
  assign shamt      = src_b[SHW-1:0];
  assign rot_multi  = {1'b0, shamt} > ROT_STEP_W;
  assign first_step = rot_multi ? ROT_STEP_W[SHW-1:0] : shamt;
  assign start_rot  = rot_multi && ((dec_op == ALU_ROL) || (dec_op == ALU_ROR)) && !dec_illegal;
  assign rot_more   = {1'b0, rem} > ROT_STEP_W;
  assign rot_step   = rot_more ? ROT_STEP_W[SHW-1:0] : rem;
  assign acc_rot    = rot_left ? rotl(acc, rot_step) : rotr(acc, rot_step);
`else
  assign start_rot  = 1'b0;
`endif

  // Single-cycle datapath; illegal ops produce zero
  always_comb begin
    alu_res = '0;
    if (dec_illegal) begin
      alu_res = '0;
    end else begin
      case (dec_op)
        ALU_ADD:  alu_res = src_a + src_b;
        ALU_SUB:  alu_res = src_a - src_b;
        ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
        ALU_OR:   alu_res = src_a | src_b;
        ALU_AND:  alu_res = src_a & src_b;
`ifdef RVX_ALU_EXT_EN
        ALU_ANDN: alu_res = src_a & ~src_b;
        ALU_ORN:  alu_res = src_a | ~src_b;
        ALU_XNOR: alu_res = ~(src_a ^ src_b);
        ALU_MIN:  alu_res = ($signed(src_a) < $signed(src_b)) ? src_a : src_b;
        ALU_MAX:  alu_res = ($signed(src_a) > $signed(src_b)) ? src_a : src_b;
        ALU_MINU: alu_res = (src_a < src_b) ? src_a : src_b;
        ALU_MAXU: alu_res = (src_a > src_b) ? src_a : src_b;
        ALU_ABS:  alu_res = src_a[XLEN-1] ? ({XLEN{1'b0}} - src_a) : src_a;
        ALU_ROL:  alu_res = rotl(src_a, first_step);
        ALU_ROR:  alu_res = rotr(src_a, first_step);
`endif
        default:  alu_res = '0;
      endcase
    end
  end

  // Next-state and output-register logic
  always_comb begin
    state_next     = state;
    out_valid_next = out_valid;
    result_next    = result;
    zero_next      = zero;
    illegal_next   = illegal;
`ifdef RVX_ALU_EXT_EN
    acc_next       = acc;
    rem_next       = rem;
    rot_left_next  = rot_left;
`endif
    if (flush) begin
      state_next     = ST_IDLE;
      out_valid_next = 1'b0;
      illegal_next   = 1'b0;
`ifdef RVX_ALU_EXT_EN
      rem_next       = '0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid_next = 1'b0;
      end else begin
        out_valid_next = out_valid;
      end
      if (accept && !start_rot) begin
        out_valid_next = 1'b1;
        result_next    = alu_res;
        zero_next      = (alu_res == '0);
        illegal_next   = dec_illegal;
      end
`ifdef RVX_ALU_EXT_EN
      else if (accept) begin
        state_next     = ST_ROT;
        acc_next       = alu_res;
        rem_next       = shamt - first_step;
        rot_left_next  = (dec_op == ALU_ROL);
      end else if (state == ST_ROT) begin
        acc_next = acc_rot;
        rem_next = rem - rot_step;
        if (!rot_more) begin
          state_next     = ST_IDLE;
          out_valid_next = 1'b1;
          result_next    = acc_rot;
          zero_next      = (acc_rot == '0);
          illegal_next   = 1'b0;
        end else begin
          state_next     = ST_ROT;
        end
      end
`endif
      else begin
        state_next = state;
      end
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
`ifdef RVX_ALU_EXT_EN
      acc       <= '0;
      rem       <= '0;
      rot_left  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      out_valid <= out_valid_next;
      result    <= result_next;
      zero      <= zero_next;
      illegal   <= illegal_next;
`ifdef RVX_ALU_EXT_EN
      acc       <= acc_next;
      rem       <= rem_next;
      rot_left  <= rot_left_next;
`endif
    end
  end

endmodule

// File: tb/tb_rvx_alu_exec.sv
// Self-checking bench for rvx_alu_exec (XLEN=32, ROT_STEP=8): directed table, corner sequences, random vs model.
module tb_rvx_alu_exec;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, opb5, zero, illegal;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] src_a, src_b, result;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvx_alu_exec #(.XLEN(32), .ROT_STEP(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .opb5(opb5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ob5;
    logic [31:0] a, b, r;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic ob5, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic ill, input int lat);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.ob5 = ob5; v.a = a; v.b = b; v.r = r; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // RVX10 entries: without the extension they are illegal single-cycle ops
  function automatic vec_t mkx(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r, input int lat);
`ifdef RVX_ALU_EXT_EN
    return mk(2'b11, f3, f7, 1'b0, a, b, r, 1'b0, lat);
`else
    return mk(2'b11, f3, f7, 1'b0, a, b, 32'h0, 1'b1, 1 + 0 * lat);
`endif
  endfunction

  task automatic set_op(input vec_t v);
    ALUOp = v.op; funct3 = v.f3; funct7 = v.f7; opb5 = v.ob5; src_a = v.a; src_b = v.b;
  endtask

  // Behavioural reference: result, illegal flag and latency from the op semantics
  function automatic void ref_alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic ob5, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
    r = 32'h0; ill = 1'b0; lat = 1;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: begin
        case (f3)
          3'd0: r = (f7[5] && ob5) ? a - b : a + b;
          3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd6: r = a | b;
          3'd7: r = a & b;
          default: ill = 1'b1;
        endcase
      end
      default: begin
`ifdef RVX_ALU_EXT_EN
        int s;
        s = int'(b[4:0]);
        if (f7 == 7'd0 && f3 == 3'd0) r = a & ~b;
        else if (f7 == 7'd0 && f3 == 3'd1) r = a | ~b;
        else if (f7 == 7'd0 && f3 == 3'd2) r = ~(a ^ b);
        else if (f7 == 7'd1 && f3 == 3'd0) r = ($signed(a) < $signed(b)) ? a : b;
        else if (f7 == 7'd1 && f3 == 3'd1) r = ($signed(a) < $signed(b)) ? b : a;
        else if (f7 == 7'd1 && f3 == 3'd2) r = (a < b) ? a : b;
        else if (f7 == 7'd1 && f3 == 3'd3) r = (a < b) ? b : a;
        else if (f7 == 7'd2 && f3 <= 3'd1) begin
          r = a;
          for (int i = 0; i < s; i++) r = (f3 == 3'd0) ? {r[30:0], r[31]} : {r[0], r[31:1]};
          lat = (s == 0) ? 1 : (s + 7) / 8;
        end
        else if (f7 == 7'd3 && f3 == 3'd0) r = ($signed(a) < 0) ? 32'd0 - a : a;
        else ill = 1'b1;
`else
        ill = 1'b1;
`endif
      end
    endcase
    if (ill) r = 32'h0;
  endfunction

  task automatic do_op(input vec_t v, input string nm);
    int  k;
    bit  got;
    @(negedge clk);
    set_op(v); in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, in_ready, 1'b1);
    k = 1; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) got = 1'b1;
      else begin
        chk({nm, "_busy_in_ready"}, in_ready, 1'b0);
        @(posedge clk);
        k++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: out_valid never rose, required within 20 cycles", nm);
    end else begin
      chk({nm, "_latency"}, k, v.lat);
      chk({nm, "_result"}, result, v.r);
      chk({nm, "_illegal"}, illegal, v.ill);
      chk({nm, "_zero"}, zero, v.r == 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] er, pr;
    logic eil, pill;
    int elat, cyc, pend_cyc;
    bit pend, exp_ov, exp_ir;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(mk(2'b10, 3'd0, 7'd0, 1'b1, 32'd5, 32'd7, 32'd12, 1'b0, 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    reset = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1'b1);

    tbl[0]  = mk(2'b10, 3'd0, 7'h00, 1'b1, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    tbl[1]  = mk(2'b10, 3'd0, 7'h20, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1);
    tbl[2]  = mk(2'b10, 3'd0, 7'h20, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    tbl[3]  = mk(2'b00, 3'd5, 7'h7F, 1'b1, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    tbl[4]  = mk(2'b01, 3'd0, 7'h00, 1'b0, 32'd3, 32'd4, 32'hFFFFFFFF, 1'b0, 1);
    tbl[5]  = mk(2'b10, 3'd2, 7'h00, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
    tbl[6]  = mk(2'b10, 3'd2, 7'h00, 1'b1, 32'd5, 32'd3, 32'd0, 1'b0, 1);
    tbl[7]  = mk(2'b10, 3'd6, 7'h00, 1'b1, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1);
    tbl[8]  = mk(2'b10, 3'd7, 7'h00, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1);
    tbl[9]  = mk(2'b10, 3'd1, 7'h00, 1'b1, 32'h1234, 32'd3, 32'h0, 1'b1, 1);
    tbl[10] = mkx(3'd0, 7'd2, 32'h80000001, 32'd20, 32'h00180000, 3);
    tbl[11] = mkx(3'd1, 7'd2, 32'h12345678, 32'd4, 32'h81234567, 1);
    tbl[12] = mkx(3'd1, 7'd2, 32'h12345678, 32'd8, 32'h78123456, 1);
    tbl[13] = mkx(3'd0, 7'd2, 32'h12345678, 32'd9, 32'h68ACF024, 2);
    tbl[14] = mkx(3'd0, 7'd2, 32'h12345678, 32'd32, 32'h12345678, 1);
    tbl[15] = mkx(3'd0, 7'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1);
    tbl[16] = mkx(3'd2, 7'd1, 32'hFFFFFFFF, 32'd1, 32'h00000001, 1);
    tbl[17] = mkx(3'd1, 7'd1, 32'hFFFFFFFF, 32'd1, 32'h00000001, 1);
    tbl[18] = mkx(3'd3, 7'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1);
    tbl[19] = mkx(3'd0, 7'd3, 32'h80000000, 32'd0, 32'h80000000, 1);
    tbl[20] = mkx(3'd0, 7'd3, 32'hFFFFFFF9, 32'd0, 32'h00000007, 1);
    tbl[21] = mkx(3'd0, 7'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1);
    tbl[22] = mkx(3'd1, 7'd0, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 1);
    tbl[23] = mkx(3'd2, 7'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0FF00FF0, 1);
    tbl[24] = mk(2'b11, 3'd1, 7'd3, 1'b0, 32'h5, 32'h6, 32'h0, 1'b1, 1);
    tbl[25] = mk(2'b11, 3'd0, 7'h40, 1'b0, 32'h5, 32'h6, 32'h0, 1'b1, 1);

    for (int i = 0; i < 26; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // Output hold under back-pressure, then same-cycle acceptance of the queued op
    @(negedge clk);
    set_op(tbl[0]); in_valid = 1'b1; out_ready = 1'b0;
    #1 chk("hold_accept", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_op(mk(2'b01, 3'd0, 7'd0, 1'b0, 32'd9, 32'd2, 32'd7, 1'b0, 1));
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", result, 32'd12);
      chk("hold_in_ready", in_ready, 1'b0);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1 chk("hold_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("hold_next_valid", out_valid, 1'b1);
    chk("hold_next_result", result, 32'd7);

    // Flush kills a held illegal result and beats a same-cycle in_valid
    @(negedge clk);
    set_op(tbl[24]); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_op(tbl[0]); flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_pre_illegal", illegal, 1'b1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_illegal", illegal, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("flush_no_accept", out_valid, 1'b0);
    end

`ifdef RVX_ALU_EXT_EN
    // Flush at T+2 of a 4-cycle rotate
    @(negedge clk);
    set_op(mk(2'b11, 3'd0, 7'd2, 1'b0, 32'h80000001, 32'd31, 32'h0, 1'b0, 4)); in_valid = 1'b1;
    #1 chk("rflush_accept", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rflush_t1_in_ready", in_ready, 1'b0);
    @(negedge clk);
    set_op(tbl[0]); in_valid = 1'b1; flush = 1'b1;
    #1 chk("rflush_t2_in_ready", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("rflush_t3_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("rflush_out_valid", out_valid, 1'b0);
      @(negedge clk);
      #1;
    end
`endif

    // Reset while work is in flight clears all outputs
    do_op(tbl[0], "pre_reset");
    @(negedge clk);
`ifdef RVX_ALU_EXT_EN
    set_op(mk(2'b11, 3'd0, 7'd2, 1'b0, 32'h80000001, 32'd31, 32'h0, 1'b0, 4)); in_valid = 1'b1;
`else
    set_op(tbl[0]); in_valid = 1'b1; out_ready = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b0;
    #1 chk("rst_mid_result_before", result, 32'd12);
    @(negedge clk);
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_zero", zero, 1'b0);
    chk("rst_mid_illegal", illegal, 1'b0);
    reset = 1'b1; out_ready = 1'b1;
    #1 chk("rst_mid_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("rst_mid_aborted", out_valid, 1'b0);
    end

    // Randomised traffic against the transaction-level model
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    cyc = 0; pend = 1'b0; pend_cyc = 0; pr = 32'h0; pill = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      flush     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      ALUOp     = 2'($urandom_range(0, 3));
      funct7    = 7'($urandom_range(0, 3));
      funct3    = 3'($urandom_range(0, 7));
      opb5      = 1'($urandom_range(0, 1));
      if (ALUOp == 2'b10) funct7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      case ($urandom_range(0, 4))
        0: src_a = 32'h80000000;
        1: src_a = 32'h0;
        default: src_a = $urandom;
      endcase
      src_b = ($urandom_range(0, 3) == 0) ? src_a : $urandom;
      ref_alu(ALUOp, funct3, funct7, opb5, src_a, src_b, er, eil, elat);
      #1;
      exp_ov = pend && (cyc >= pend_cyc);
      exp_ir = !flush && (!pend || (exp_ov && out_ready));
      chk("rnd_out_valid", out_valid, exp_ov);
      chk("rnd_in_ready", in_ready, exp_ir);
      if (exp_ov && out_valid) begin
        chk("rnd_result", result, pr);
        chk("rnd_illegal", illegal, pill);
        chk("rnd_zero", zero, pr == 32'h0);
      end
      if (flush) pend = 1'b0;
      else begin
        if (exp_ov && out_ready) pend = 1'b0;
        if (in_valid && exp_ir) begin
          pend = 1'b1; pend_cyc = cyc + elat; pr = er; pill = eil;
        end
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
